// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Provides the FSM state type and the rotating-priority select function.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // First requester found scanning last_idx+1 .. last_idx+4 (mod 4); last_idx itself is scanned last.
   function automatic logic [IDX_W-1:0] next_idx(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last_idx);
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] sel;
      logic             found;
      sel   = last_idx;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = last_idx + IDX_W'(k);
         if (!found && req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/dec2to4_en.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module dec2to4_en
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N_REQ-1:0] y
);

   always_comb begin
      y = '0;
      if (en) y[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter for 4 requesters with bounded hold time and registered grant.
// Optional macro ARB_LOCK_EN adds a lock input that suppresses expiry preemption.
module rr_arb4_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             valid_q, valid_d;

   logic             lock_act;
   logic             others;
   logic [IDX_W-1:0] sel;

`ifdef ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   // In GRANT last_q equals the owner, so one scan serves both first grant and rotation.
   assign sel    = next_idx(req, last_q);
   assign others = |(req & ~(N_REQ'(1) << idx_q));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      if (!en) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  state_d = ST_GRANT;
                  idx_d   = sel;
                  last_d  = sel;
                  hold_d  = '0;
                  valid_d = 1'b1;
               end
            end
            ST_GRANT: begin
               // Release and expiry share the hand-off path; a locked owner never expires.
               if (!req[idx_q] || (hold_q >= HOLD_LAST && !lock_act)) begin
                  if (others) begin
                     idx_d   = sel;
                     last_d  = sel;
                     hold_d  = '0;
                  end else if (!req[idx_q]) begin
                     state_d = ST_IDLE;
                     valid_d = 1'b0;
                     hold_d  = '0;
                  end else begin
                     hold_d  = '0;
                  end
               end else if (hold_q < HOLD_LAST) begin
                  hold_d = hold_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

   dec2to4_en u_dec (
      .idx (idx_q),
      .en  (valid_q),
      .y   (gnt)
   );

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Scoreboard bench for rr_arb4_ctrl: expected grants queued with stimulus, popped after each edge.
// A second instance with MAX_HOLD=1 shares the inputs to cover per-cycle rotation.
module tb_rr_arb4_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] req = 4'b0000;
`ifdef ARB_LOCK_EN
   logic       lock = 1'b0;
`endif
   logic [3:0] gnt, gnt1;
   logic [1:0] gnt_idx, gnt_idx1;
   logic       gnt_valid, gnt_valid1;

   logic [3:0] exp_q[$];
   logic [3:0] exp1_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   rr_arb4_ctrl #(.MAX_HOLD(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
   );

   rr_arb4_ctrl #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] e;
      rst_n = 1'b0; en = 1'b0; req = 4'b0000;
      #7;
      exp_q.push_back(4'b0000);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_valid !== 1'b0 || gnt_idx !== 2'b00) begin
         miscompares++;
         $display("FAIL reset gnt=%b valid=%b idx=%0d exp gnt=%b valid=0 idx=0", gnt, gnt_valid, gnt_idx, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_rotation();
      logic [3:0] e, e1;
      logic [3:0] one = 4'b0001;
      en = 1'b1; req = 4'b1111;
      for (int k = 0; k < 40; k++) begin
         exp_q.push_back(one << ((k / 8) % 4));
         exp1_q.push_back(one << (k % 4));
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         e = exp_q.pop_front();
         e1 = exp1_q.pop_front();
         vectors++;
         if (gnt !== e || gnt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rotation cyc=%0d gnt=%b valid=%b exp=%b valid=1", k, gnt, gnt_valid, e);
         end
         vectors++;
         if (gnt1 !== e1) begin
            miscompares++;
            $display("FAIL rotation_hold1 cyc=%0d gnt=%b exp=%b", k, gnt1, e1);
         end
      end
      req = 4'b0000;
      exp_q.push_back(4'b0000);
      exp1_q.push_back(4'b0000);
      tick();
      e = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_valid !== 1'b0 || gnt1 !== e1) begin
         miscompares++;
         $display("FAIL rotation_release gnt=%b gnt1=%b valid=%b exp=%b/%b", gnt, gnt1, gnt_valid, e, e1);
      end
   endtask

   task automatic test_pulse();
      logic [3:0] e;
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      tick();
      req = 4'b0000;
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_idx !== 2'd2) begin
         miscompares++;
         $display("FAIL pulse_grant gnt=%b idx=%0d exp=%b idx=2", gnt, gnt_idx, e);
      end
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      for (int k = 0; k < 2; k++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (gnt !== e || gnt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_idle cyc=%0d gnt=%b valid=%b exp=%b", k, gnt, gnt_valid, e);
         end
      end
   endtask

   task automatic test_single_owner();
      logic [3:0] e;
      req = 4'b0010;
      for (int k = 0; k < 20; k++) exp_q.push_back(4'b0010);
      for (int k = 0; k < 20; k++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (gnt !== e) begin
            miscompares++;
            $display("FAIL single_owner cyc=%0d gnt=%b exp=%b", k, gnt, e);
         end
      end
      req = 4'b0000;
      exp_q.push_back(4'b0000);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL single_release gnt=%b exp=%b", gnt, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] reqs [4] = '{4'b0001, 4'b1001, 4'b1000, 4'b0000};
      logic [3:0] exps [4] = '{4'b0001, 4'b0001, 4'b1000, 4'b0000};
      logic [3:0] e;
      for (int k = 0; k < 4; k++) begin
         req = reqs[k];
         exp_q.push_back(exps[k]);
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (gnt !== e) begin
            miscompares++;
            $display("FAIL back_to_back step=%0d gnt=%b exp=%b", k, gnt, e);
         end
      end
   endtask

   task automatic test_reset_and_enable();
      logic [3:0] e;
      en = 1'b1; req = 4'b1111;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0001);
      for (int k = 0; k < 2; k++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (gnt !== e) begin
            miscompares++;
            $display("FAIL pre_reset cyc=%0d gnt=%b exp=%b", k, gnt, e);
         end
      end
      #2 rst_n = 1'b0;
      exp_q.push_back(4'b0000);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset gnt=%b valid=%b exp=%b valid=0", gnt, gnt_valid, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(4'b0001);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL post_reset_grant gnt=%b exp=%b", gnt, e);
      end
      en = 1'b0;
      exp_q.push_back(4'b0000);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL en_low gnt=%b valid=%b exp=%b", gnt, gnt_valid, e);
      end
      en = 1'b1;
      exp_q.push_back(4'b0010);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e || gnt_idx !== 2'd1) begin
         miscompares++;
         $display("FAIL en_resume gnt=%b idx=%0d exp=%b idx=1", gnt, gnt_idx, e);
      end
      req = 4'b0000;
      exp_q.push_back(4'b0000);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL en_release gnt=%b exp=%b", gnt, e);
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      logic [3:0] e;
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL lock_grant gnt=%b exp=%b", gnt, e);
      end
      req = 4'b1111; lock = 1'b1;
      for (int k = 0; k < 12; k++) exp_q.push_back(4'b0100);
      for (int k = 0; k < 12; k++) begin
         tick();
         e = exp_q.pop_front();
         vectors++;
         if (gnt !== e) begin
            miscompares++;
            $display("FAIL lock_hold cyc=%0d gnt=%b exp=%b", k, gnt, e);
         end
      end
      lock = 1'b0;
      exp_q.push_back(4'b1000);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL lock_release gnt=%b exp=%b", gnt, e);
      end
      req = 4'b0000;
      exp_q.push_back(4'b0000);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e) begin
         miscompares++;
         $display("FAIL lock_idle gnt=%b exp=%b", gnt, e);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rotation();
      test_pulse();
      test_single_owner();
      test_back_to_back();
      test_reset_and_enable();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
